// File: rtl/assoc_data_cache.sv
// 2-way set-associative write-back, write-allocate data cache with LRU eviction.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module assoc_data_cache #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 16,
    parameter int SETS            = 32,
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W,
    localparam int BLK_W = DATA_W * WORDS_PER_BLOCK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_done,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    output logic [BLK_W-1:0]        mem_wblock,
    input  logic [BLK_W-1:0]        mem_rblock,
    input  logic                    mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, DONE} state_t;

    state_t state, state_nxt;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              first;
    logic              vic;

    logic [1:0]        valid [SETS];
    logic [1:0]        dirty [SETS];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tags  [SETS][2];
    logic [DATA_W-1:0] data  [SETS][2][WORDS_PER_BLOCK];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             hit0, hit1, hit, hit_way;
    logic             miss_vic, vic_dirty;

    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign idx     = req_addr[OFF_W +: IDX_W];
    assign off     = req_addr[OFF_W-1:0];

    assign hit0    = valid[idx][0] && (tags[idx][0] == req_tag);
    assign hit1    = valid[idx][1] && (tags[idx][1] == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;

    // Fill empty ways first, in order, before evicting by LRU
    assign miss_vic  = !valid[idx][0] ? 1'b0 :
                       !valid[idx][1] ? 1'b1 : lru[idx];
    assign vic_dirty = valid[idx][miss_vic] & dirty[idx][miss_vic];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cpu_req) state_nxt = LOOKUP;
            LOOKUP: begin
                if (hit)            state_nxt = DONE;
                else if (vic_dirty) state_nxt = WRITEBACK;
                else                state_nxt = REFILL;
            end
            WRITEBACK: if (mem_ack) state_nxt = REFILL;
            REFILL:    if (mem_ack) state_nxt = LOOKUP;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_done   = (state == DONE);
        mem_req    = (state == WRITEBACK) || (state == REFILL);
        mem_we     = (state == WRITEBACK);
        mem_addr   = '0;
        mem_wblock = '0;
        if (state == WRITEBACK) begin
            mem_addr = {tags[idx][vic], idx};
            for (int w = 0; w < WORDS_PER_BLOCK; w++)
                mem_wblock[w*DATA_W +: DATA_W] = data[idx][vic][w];
        end else if (state == REFILL) begin
            mem_addr = {req_tag, idx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cpu_rdata <= '0;
            first     <= 1'b0;
            vic       <= 1'b0;
            lru       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        first     <= 1'b1;
                    end
                end
                LOOKUP: begin
                    first <= 1'b0;
                    if (hit) begin
                        if (req_we) dirty[idx][hit_way] <= 1'b1;
                        else        cpu_rdata <= data[idx][hit_way][off];
                        lru[idx] <= ~hit_way;
                    end else begin
                        vic <= miss_vic;
                    end
                end
                WRITEBACK: if (mem_ack) dirty[idx][vic] <= 1'b0;
                REFILL: begin
                    if (mem_ack) begin
                        valid[idx][vic] <= 1'b1;
                        dirty[idx][vic] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (state == LOOKUP && hit && req_we)
            data[idx][hit_way][off] <= req_wdata;
        if (state == REFILL && mem_ack) begin
            tags[idx][vic] <= req_tag;
            for (int w = 0; w < WORDS_PER_BLOCK; w++)
                data[idx][vic][w] <= mem_rblock[w*DATA_W +: DATA_W];
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && first) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed testbench for assoc_data_cache with a simple one-cycle-ack memory.
// Stats checks are compiled in when DCACHE_STATS_EN is defined.
module tb_assoc_data_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [15:0]  cpu_addr, cpu_wdata;
    logic         cpu_done;
    logic [15:0]  cpu_rdata;
    logic         mem_req, mem_we;
    logic [11:0]  mem_addr;
    logic [255:0] mem_wblock, mem_rblock;
    logic         mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    assoc_data_cache dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wblock(mem_wblock),
        .mem_rblock(mem_rblock), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int           n_mem;
    int           lat;
    logic         done_seen;
    logic [15:0]  rdata_obs;
    logic         mwe_q   [4];
    logic [11:0]  maddr_q [4];
    logic [255:0] wblk_q  [4];
    logic [255:0] rblock_src;

    function automatic logic [255:0] mk_block(input logic [15:0] base);
        logic [255:0] b;
        for (int i = 0; i < 16; i++) b[i*16 +: 16] = base + 16'(i);
        return b;
    endfunction

    task automatic run_access(input logic we, input logic [15:0] addr,
                              input logic [15:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        n_mem = 0; done_seen = 1'b0; lat = 0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            @(posedge clk); #1;
            lat++;
            mem_ack = 1'b0;
            if (cpu_done) begin
                done_seen = 1'b1;
                rdata_obs = cpu_rdata;
                cpu_req   = 1'b0;
            end else if (mem_req) begin
                if (n_mem < 4) begin
                    mwe_q[n_mem]   = mem_we;
                    maddr_q[n_mem] = mem_addr;
                    wblk_q[n_mem]  = mem_wblock;
                end
                n_mem++;
                mem_ack    = 1'b1;
                mem_rblock = rblock_src;
            end
        end
        cpu_req = 1'b0; mem_ack = 1'b0;
        tests++;
        if (done_seen !== 1'b1) begin
            fails++;
            $display("FAIL access_timeout addr=%h got done=%b want 1", addr, done_seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rblock = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cpu_done !== 1'b0 || cpu_rdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_cpu got done=%b rdata=%h want 0 0000", cpu_done, cpu_rdata);
        end
        tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_mem_ctl got req=%b we=%b want 0 0", mem_req, mem_we);
        end
        tests++;
        if (mem_addr !== 12'h0 || mem_wblock !== 256'h0) begin
            fails++;
            $display("FAIL reset_mem_bus got addr=%h wblock=%h want 0", mem_addr, mem_wblock);
        end
`ifdef DCACHE_STATS_EN
        tests++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", hit_count, miss_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_refill_read();
        rblock_src = mk_block(16'h1000);
        rblock_src[3*16 +: 16] = 16'hBEEF;
        run_access(1'b0, 16'h0123, 16'h0);
        tests++;
        if (n_mem !== 1 || mwe_q[0] !== 1'b0 || maddr_q[0] !== 12'h012) begin
            fails++;
            $display("FAIL refill_req got n=%0d we=%b addr=%h want 1 0 012",
                     n_mem, mwe_q[0], maddr_q[0]);
        end
        tests++;
        if (rdata_obs !== 16'hBEEF) begin
            fails++;
            $display("FAIL refill_rdata got %h want beef", rdata_obs);
        end
    endtask

    task automatic test_hit_read();
        rblock_src = mk_block(16'h5000);
        run_access(1'b0, 16'h0123, 16'h0);
        tests++;
        if (n_mem !== 0 || lat !== 2) begin
            fails++;
            $display("FAIL hit_read_timing got n=%0d lat=%0d want 0 2", n_mem, lat);
        end
        tests++;
        if (rdata_obs !== 16'hBEEF) begin
            fails++;
            $display("FAIL hit_read_rdata got %h want beef", rdata_obs);
        end
    endtask

    task automatic test_write_evict();
        run_access(1'b1, 16'h0125, 16'h1234);
        tests++;
        if (n_mem !== 0 || lat !== 2 || cpu_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL write_hit got n=%0d lat=%0d rdata=%h want 0 2 beef",
                     n_mem, lat, cpu_rdata);
        end
        rblock_src = mk_block(16'h2000);
        run_access(1'b0, 16'h0323, 16'h0);
        tests++;
        if (n_mem !== 1 || mwe_q[0] !== 1'b0 || maddr_q[0] !== 12'h032 ||
            rdata_obs !== 16'h2003) begin
            fails++;
            $display("FAIL way1_refill got n=%0d we=%b addr=%h rdata=%h want 1 0 032 2003",
                     n_mem, mwe_q[0], maddr_q[0], rdata_obs);
        end
        rblock_src = mk_block(16'h3000);
        run_access(1'b0, 16'h0523, 16'h0);
        tests++;
        if (n_mem !== 2 || mwe_q[0] !== 1'b1 || maddr_q[0] !== 12'h012) begin
            fails++;
            $display("FAIL wb_req got n=%0d we=%b addr=%h want 2 1 012",
                     n_mem, mwe_q[0], maddr_q[0]);
        end
        tests++;
        if (wblk_q[0][5*16 +: 16] !== 16'h1234 || wblk_q[0][3*16 +: 16] !== 16'hBEEF) begin
            fails++;
            $display("FAIL wb_data got w5=%h w3=%h want 1234 beef",
                     wblk_q[0][5*16 +: 16], wblk_q[0][3*16 +: 16]);
        end
        tests++;
        if (mwe_q[1] !== 1'b0 || maddr_q[1] !== 12'h052 || rdata_obs !== 16'h3003) begin
            fails++;
            $display("FAIL evict_refill got we=%b addr=%h rdata=%h want 0 052 3003",
                     mwe_q[1], maddr_q[1], rdata_obs);
        end
`ifdef DCACHE_STATS_EN
        tests++;
        if (hit_count !== 16'd2 || miss_count !== 16'd3) begin
            fails++;
            $display("FAIL stats_seq got %0d/%0d want 2/3", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mem_req !== 1'b0 || cpu_done !== 1'b0) begin
            fails++;
            $display("FAIL ack_idle got req=%b done=%b want 0 0", mem_req, cpu_done);
        end
        rblock_src = mk_block(16'h6000);
        run_access(1'b0, 16'h0323, 16'h0);
        tests++;
        if (n_mem !== 0 || lat !== 2 || rdata_obs !== 16'h2003) begin
            fails++;
            $display("FAIL ack_idle_hit got n=%0d lat=%0d rdata=%h want 0 2 2003",
                     n_mem, lat, rdata_obs);
        end
`ifdef DCACHE_STATS_EN
        tests++;
        if (hit_count !== 16'd3 || miss_count !== 16'd3) begin
            fails++;
            $display("FAIL stats_ack_idle got %0d/%0d want 3/3", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_reset_refill();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0923;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (mem_req) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h092) begin
            fails++;
            $display("FAIL rr_refill got seen=%b we=%b addr=%h want 1 0 092",
                     seen, mem_we, mem_addr);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_addr !== 12'h0 || cpu_rdata !== 16'h0) begin
            fails++;
            $display("FAIL rr_async got req=%b addr=%h rdata=%h want 0 000 0000",
                     mem_req, mem_addr, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rblock_src = mk_block(16'h7000);
        run_access(1'b0, 16'h0123, 16'h0);
        tests++;
        if (n_mem !== 1 || mwe_q[0] !== 1'b0 || maddr_q[0] !== 12'h012 ||
            rdata_obs !== 16'h7003) begin
            fails++;
            $display("FAIL rr_remiss got n=%0d we=%b addr=%h rdata=%h want 1 0 012 7003",
                     n_mem, mwe_q[0], maddr_q[0], rdata_obs);
        end
`ifdef DCACHE_STATS_EN
        tests++;
        if (hit_count !== 16'd0 || miss_count !== 16'd1) begin
            fails++;
            $display("FAIL stats_after_rst got %0d/%0d want 0/1", hit_count, miss_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_refill_read();
        test_hit_read();
        test_write_evict();
        test_ack_idle();
        test_reset_refill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
